// File: rtl/alu_arbiter_pkg.sv
// Shared opcode encodings and helpers for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  localparam int ALU_W = 32;

  typedef logic [3:0] op_t;

  localparam op_t OP_ADD = 4'd0;
  localparam op_t OP_SUB = 4'd1;
  localparam op_t OP_NOT = 4'd2;
  localparam op_t OP_AND = 4'd3;
  localparam op_t OP_OR  = 4'd4;
  localparam op_t OP_XOR = 4'd5;
  localparam op_t OP_SLL = 4'd6;
  localparam op_t OP_SRL = 4'd7;
  localparam op_t OP_SRA = 4'd8;
  localparam op_t OP_MAX = 4'd8;

  function automatic logic op_legal(input op_t op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester's request and response valid/ready channels toward the ALU arbiter.
interface alu_arbiter_if #(
  parameter int W = 32
);
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [3:0]   req_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one grant per cycle, pointer moves past each granted requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (!req_i[1] || !ptr_q)) gnt_o[0] = 1'b1;
    else if (req_i[1])                     gnt_o[1] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[0])      ptr_d = 1'b1;
    else if (gnt_o[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one pipelined ALU between two valid/ready requesters with round-robin grants.
// Build option: define ALU_ARB_OPCHECK_EN to trap opcodes above OP_MAX without issuing them.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W       = ALU_W,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave req0_if,
  alu_arbiter_if.slave req1_if,
  output logic [W-1:0] alu_operand_a_o,
  output logic [W-1:0] alu_operand_b_o,
  output logic [3:0]   alu_op_o,
  input  logic [W-1:0] alu_result_i,
  output logic         busy_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FLIGHT = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]         req_valid, rsp_ready, elig, gnt;
  logic [1:0][W-1:0]  req_a, req_b;
  logic [1:0][3:0]    req_op;
  logic [1:0][1:0]    state_q, state_d;
  logic [1:0][W-1:0]  res_q;
  logic [1:0]         err_q, bad_q, bad_d;
  logic [W-1:0]       alu_a_q, alu_b_q, a_sel, b_sel;
  logic [3:0]         alu_op_q, op_sel;
  logic [ALU_LAT-1:0] trk_vld_q, trk_tag_q;
  logic               gidx, issue, cap, cap_tag;

  assign req_valid = {req1_if.req_valid, req0_if.req_valid};
  assign rsp_ready = {req1_if.rsp_ready, req0_if.rsp_ready};
  assign req_a     = {req1_if.req_a, req0_if.req_a};
  assign req_b     = {req1_if.req_b, req0_if.req_b};
  assign req_op    = {req1_if.req_op, req0_if.req_op};

  always_comb begin
    elig = 2'b00;
    for (int n = 0; n < 2; n++) elig[n] = (state_q[n] == S_IDLE) && req_valid[n];
  end

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (elig),
    .gnt_o (gnt)
  );

  assign gidx   = gnt[1];
  assign a_sel  = req_a[gidx];
  assign b_sel  = req_b[gidx];
  assign op_sel = req_op[gidx];

`ifdef ALU_ARB_OPCHECK_EN
  // Illegal opcodes still win the grant but bypass the ALU and finish one edge later.
  assign issue = (|gnt) && op_legal(op_sel);
  assign bad_d = ((|gnt) && !op_legal(op_sel)) ? gnt : 2'b00;
`else
  assign issue = |gnt;
  assign bad_d = 2'b00;
`endif

  // Issue stage: drive the ALU and enter the op into the latency tracker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      trk_vld_q <= '0;
      trk_tag_q <= '0;
      bad_q     <= '0;
    end else begin
      if (issue) begin
        alu_a_q  <= a_sel;
        alu_b_q  <= b_sel;
        alu_op_q <= op_sel;
      end
      trk_vld_q[0] <= issue;
      trk_tag_q[0] <= gidx;
      for (int i = 1; i < ALU_LAT; i++) begin
        trk_vld_q[i] <= trk_vld_q[i-1];
        trk_tag_q[i] <= trk_tag_q[i-1];
      end
      bad_q <= bad_d;
    end
  end

  assign cap     = trk_vld_q[ALU_LAT-1];
  assign cap_tag = trk_tag_q[ALU_LAT-1];

  always_comb begin
    state_d = state_q;
    for (int n = 0; n < 2; n++) begin
      case (state_q[n])
        S_IDLE:   if (gnt[n]) state_d[n] = S_FLIGHT;
        S_FLIGHT: if (bad_q[n] || (cap && cap_tag == 1'(n))) state_d[n] = S_DONE;
        S_DONE:   if (rsp_ready[n]) state_d[n] = S_IDLE;
        default:  state_d[n] = S_IDLE;
      endcase
    end
  end

  // Capture stage: result lands in the owning slot, held until the next capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= {S_IDLE, S_IDLE};
      res_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      for (int n = 0; n < 2; n++) begin
        if (state_q[n] == S_FLIGHT) begin
          if (bad_q[n]) begin
            res_q[n] <= '0;
            err_q[n] <= 1'b1;
          end else if (cap && cap_tag == 1'(n)) begin
            res_q[n] <= alu_result_i;
            err_q[n] <= 1'b0;
          end
        end
      end
    end
  end

  assign req0_if.req_ready  = gnt[0];
  assign req1_if.req_ready  = gnt[1];
  assign req0_if.rsp_valid  = (state_q[0] == S_DONE);
  assign req1_if.rsp_valid  = (state_q[1] == S_DONE);
  assign req0_if.rsp_result = res_q[0];
  assign req1_if.rsp_result = res_q[1];
  assign req0_if.rsp_err    = err_q[0];
  assign req1_if.rsp_err    = err_q[1];

  assign alu_operand_a_o = alu_a_q;
  assign alu_operand_b_o = alu_b_q;
  assign alu_op_o        = alu_op_q;
  assign busy_o          = (state_q[0] != S_IDLE) || (state_q[1] != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.W(W)) r0 ();
  alu_arbiter_if #(.W(W)) r1 ();

  logic [W-1:0] alu_a, alu_b, alu_res;
  logic [3:0]   alu_op;
  logic         busy;

  alu_arbiter #(.W(W), .ALU_LAT(LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0_if         (r0),
    .req1_if         (r1),
    .alu_operand_a_o (alu_a),
    .alu_operand_b_o (alu_b),
    .alu_op_o        (alu_op),
    .alu_result_i    (alu_res),
    .busy_o          (busy)
  );

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_NOT:  return ~a;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return W'($signed(a) >>> b[4:0]);
      default: return '0;
    endcase
  endfunction

  function automatic logic ref_err(input logic [3:0] op);
`ifdef ALU_ARB_OPCHECK_EN
    return op > OP_MAX;
`else
    return (op != op);
`endif
  endfunction

  // Single-cycle ALU stand-in driven by the arbiter's registered outputs.
  assign alu_res = ref_alu(alu_op, alu_a, alu_b);

  typedef struct packed {
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  logic out_m [2];
  int   age_m [2];
  logic ptr_m;
  exp_t q0 [$];
  exp_t q1 [$];
  int   gq [$];
  int   hs_cnt [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (n == 0) begin
      r0.req_valid = v; r0.req_op = op; r0.req_a = a; r0.req_b = b;
    end else begin
      r1.req_valid = v; r1.req_op = op; r1.req_a = a; r1.req_b = b;
    end
  endtask

  task automatic clear_model();
    for (int n = 0; n < 2; n++) begin
      out_m[n] = 1'b0;
      age_m[n] = 0;
    end
    ptr_m = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  // One clock: check outputs against the model before the edge, then advance the model across it.
  task automatic cycle();
    logic v [2], rdy [2], rv [2], rr [2], er [2], elig [2], hs [2], expv;
    logic [W-1:0] a [2], b [2], rs [2];
    logic [3:0] op [2];
    exp_t e;
    int g;
    @(negedge clk);
    v[0] = r0.req_valid; rdy[0] = r0.req_ready; rv[0] = r0.rsp_valid; rr[0] = r0.rsp_ready;
    er[0] = r0.rsp_err;  a[0] = r0.req_a; b[0] = r0.req_b; rs[0] = r0.rsp_result; op[0] = r0.req_op;
    v[1] = r1.req_valid; rdy[1] = r1.req_ready; rv[1] = r1.rsp_valid; rr[1] = r1.rsp_ready;
    er[1] = r1.rsp_err;  a[1] = r1.req_a; b[1] = r1.req_b; rs[1] = r1.rsp_result; op[1] = r1.req_op;
    for (int n = 0; n < 2; n++) elig[n] = !out_m[n] && v[n];
    g = -1;
    if (elig[0] && elig[1]) g = ptr_m ? 1 : 0;
    else if (elig[0])       g = 0;
    else if (elig[1])       g = 1;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("req%0d_ready", n), 64'(rdy[n]), 64'(g == n));
      expv = out_m[n] && (age_m[n] >= LAT);
      chk($sformatf("rsp%0d_valid", n), 64'(rv[n]), 64'(expv));
      hs[n] = expv && rr[n];
      if (hs[n]) begin
        if (n == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("rsp%0d_result", n), 64'(rs[n]), 64'(e.res));
        chk($sformatf("rsp%0d_err", n), 64'(er[n]), 64'(e.err));
        hs_cnt[n]++;
      end
    end
    chk("busy", 64'(busy), 64'(out_m[0] || out_m[1]));
    for (int n = 0; n < 2; n++) begin
      if (hs[n])         out_m[n] = 1'b0;
      else if (out_m[n]) age_m[n]++;
    end
    if (g >= 0) begin
      out_m[g] = 1'b1;
      age_m[g] = 0;
      e.err = ref_err(op[g]);
      e.res = e.err ? '0 : ref_alu(op[g], a[g], b[g]);
      if (g == 0) q0.push_back(e);
      else        q1.push_back(e);
      ptr_m = (g == 0);
      gq.push_back(g);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 1'b0, OP_ADD, '0, '0);
    set_req(1, 1'b0, OP_ADD, '0, '0);
    r0.rsp_ready = 1'b0;
    r1.rsp_ready = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    set_req(0, 1'b0, OP_ADD, '0, '0);
    set_req(1, 1'b0, OP_ADD, '0, '0);
    r0.rsp_ready = 1'b1;
    r1.rsp_ready = 1'b1;
    repeat (4) cycle();
    r0.rsp_ready = 1'b0;
    r1.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ta, tb, held;
    int h1, n0, n1;
    hs_cnt[0] = 0;
    hs_cnt[1] = 0;

    // Reset state
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rsp0_valid", 64'(r0.rsp_valid), 64'd0);
    chk("rst_rsp1_valid", 64'(r1.rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_rsp0_result", 64'(r0.rsp_result), 64'd0);
    chk("rst_rsp1_err", 64'(r1.rsp_err), 64'd0);
    rst_n = 1'b1;

    // Single ADD
    set_req(0, 1'b1, OP_ADD, 32'hAABBCCDD, 32'hE1223341);
    cycle();
    chk("t1_alu_a", 64'(alu_a), 64'h0000_0000_AABB_CCDD);
    chk("t1_alu_op", 64'(alu_op), 64'(OP_ADD));
    set_req(0, 1'b0, OP_ADD, '0, '0);
    cycle();
    chk("t1_rsp0_valid", 64'(r0.rsp_valid), 64'd1);
    chk("t1_rsp0_result", 64'(r0.rsp_result), 64'h0000_0000_8BDE_001E);
    r0.rsp_ready = 1'b1;
    cycle();
    r0.rsp_ready = 1'b0;
    chk("t1_rsp0_released", 64'(r0.rsp_valid), 64'd0);

    // Collision straight after reset
    do_reset();
    gq.delete();
    set_req(0, 1'b1, OP_SUB, 32'hAABBCCDD, 32'hE1223341);
    set_req(1, 1'b1, OP_AND, 32'hAABBCCDD, 32'hE1223341);
    cycle();
    set_req(0, 1'b0, OP_ADD, '0, '0);
    cycle();
    set_req(1, 1'b0, OP_ADD, '0, '0);
    chk("t2_grants", 64'(gq.size()), 64'd2);
    if (gq.size() == 2) begin
      chk("t2_first_grant", 64'(gq[0]), 64'd0);
      chk("t2_second_grant", 64'(gq[1]), 64'd1);
    end
    chk("t2_rsp0_result", 64'(r0.rsp_result), 64'h0000_0000_C999_999C);
    cycle();
    chk("t2_rsp1_valid", 64'(r1.rsp_valid), 64'd1);
    chk("t2_rsp1_result", 64'(r1.rsp_result), 64'h0000_0000_A022_0041);
    drain();

    // Backpressure on requester 0 while requester 1 keeps running
    ta = $urandom;
    tb = $urandom;
    held = ref_alu(OP_XOR, ta, tb);
    set_req(0, 1'b1, OP_XOR, ta, tb);
    r1.rsp_ready = 1'b1;
    set_req(1, 1'b1, 4'($urandom_range(0, 8)), $urandom, $urandom);
    cycle();
    cycle();
    h1 = hs_cnt[1];
    for (int i = 0; i < 10; i++) begin
      set_req(1, 1'b1, 4'($urandom_range(0, 8)), $urandom, $urandom);
      cycle();
      chk("t3_req0_ready", 64'(r0.req_ready), 64'd0);
      chk("t3_rsp0_hold", 64'(r0.rsp_result), 64'(held));
    end
    chk("t3_req1_progress", 64'(hs_cnt[1] - h1 >= 3), 64'd1);
    drain();

    // Fairness under continuous contention
    gq.delete();
    r0.rsp_ready = 1'b1;
    r1.rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_req(0, 1'b1, 4'($urandom_range(0, 8)), $urandom, $urandom);
      set_req(1, 1'b1, 4'($urandom_range(0, 8)), $urandom, $urandom);
      cycle();
    end
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < gq.size(); i++) begin
      if (gq[i] == 0) n0++;
      else            n1++;
      if (i > 0) chk("t4_alternate", 64'(gq[i]), 64'(1 - gq[i-1]));
    end
    chk("t4_req0_served", 64'(n0 >= 6), 64'd1);
    chk("t4_req1_served", 64'(n1 >= 6), 64'd1);
    drain();

    // Reset while an op is in flight
    set_req(0, 1'b1, OP_ADD, 32'h1234_5678, 32'h1111_1111);
    cycle();
    set_req(0, 1'b0, OP_ADD, '0, '0);
    rst_n = 1'b0;
    #1;
    chk("t5_rsp0_valid", 64'(r0.rsp_valid), 64'd0);
    chk("t5_rsp1_valid", 64'(r1.rsp_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_alu_a", 64'(alu_a), 64'd0);
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0.rsp_ready = 1'b1;
    r1.rsp_ready = 1'b1;
    repeat (3) cycle();
    gq.delete();
    set_req(0, 1'b1, OP_OR, $urandom, $urandom);
    set_req(1, 1'b1, OP_OR, $urandom, $urandom);
    cycle();
    chk("t5_first_grant_after_reset", 64'(gq.size() > 0 ? gq[0] : -1), 64'd0);
    drain();

    // Opcode above the legal range
    set_req(0, 1'b1, OP_OR, 32'h0F0F_0000, 32'h0000_00F0);
    cycle();
    drain();
    set_req(1, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0000_0003);
    cycle();
    set_req(1, 1'b0, OP_ADD, '0, '0);
`ifdef ALU_ARB_OPCHECK_EN
    chk("t6_alu_op", 64'(alu_op), 64'(OP_OR));
    chk("t6_alu_a", 64'(alu_a), 64'h0000_0000_0F0F_0000);
`else
    chk("t6_alu_op", 64'(alu_op), 64'hF);
    chk("t6_alu_a", 64'(alu_a), 64'h0000_0000_DEAD_BEEF);
`endif
    cycle();
    chk("t6_rsp1_valid", 64'(r1.rsp_valid), 64'd1);
    chk("t6_rsp1_err", 64'(r1.rsp_err), 64'(ref_err(4'hF)));
    chk("t6_rsp1_result", 64'(r1.rsp_result), 64'd0);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++)
        set_req(n, 1'($urandom_range(0, 3) != 0),
                ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 8)),
                $urandom, $urandom);
      r0.rsp_ready = 1'($urandom_range(0, 3) != 0);
      r1.rsp_ready = 1'($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
